// File: rtl/pipe_issue_ctrl.sv
// Issue sequencer for a fixed-latency datapath stage: one operand address per beat, credit-throttled,
// with LATENCY-aligned result strobes. Defining PIPE_ISSUE_PERF_EN adds the stall_cycles counter.
module pipe_issue_ctrl #(
  parameter int LATENCY = 4,
  parameter int CNT_W   = 16,
  parameter int ADDR_W  = 10,
  parameter int CREDITS = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [CNT_W-1:0]  len,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              credit_ret,
  output logic              busy,
  output logic              done,
  output logic              issue_valid,
  output logic [ADDR_W-1:0] issue_addr,
  output logic              issue_last,
  output logic              res_valid,
  output logic              res_last,
  output logic              credit_err
`ifdef PIPE_ISSUE_PERF_EN
  ,
  output logic [31:0]       stall_cycles
`endif
);

  localparam int                CRED_W   = $clog2(CREDITS + 1);
  localparam logic [CRED_W-1:0] CRED_MAX = CRED_W'(CREDITS);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [CNT_W-1:0]    rem_q, rem_d;
  logic [CRED_W-1:0]   credits_q, credits_d;
  logic [LATENCY-1:0]  vld_sr_q, vld_sr_d;
  logic [LATENCY-1:0]  last_sr_q, last_sr_d;
  logic                credit_err_q, credit_err_d;
  logic                ret_ok;
`ifdef PIPE_ISSUE_PERF_EN
  logic [31:0]         stall_q, stall_d;
`endif

  always_comb begin
    // NOTE: every signal written here is given a default first, so no path can infer a latch.
    state_d      = state_q;
    addr_d       = addr_q;
    rem_d        = rem_q;
    credit_err_d = credit_err_q;

    issue_valid = (state_q == S_ISSUE) && (credits_q != '0);
    issue_last  = issue_valid && (rem_q == CNT_W'(1));
    issue_addr  = issue_valid ? addr_q : '0;

    // A return while already fully credited is dropped and flagged; it must not overflow credits.
    ret_ok = credit_ret && (credits_q != CRED_MAX);
    if (credit_ret && !ret_ok) credit_err_d = 1'b1;
    credits_d = credits_q - CRED_W'(issue_valid) + CRED_W'(ret_ok);

    vld_sr_d  = LATENCY'({vld_sr_q, issue_valid});
    last_sr_d = LATENCY'({last_sr_q, issue_last});

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          if (len != '0) begin
            state_d = S_ISSUE;
            addr_d  = base_addr;
            rem_d   = len;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_ISSUE: begin
        if (issue_valid) begin
          addr_d = addr_q + ADDR_W'(1);
          rem_d  = rem_q - CNT_W'(1);
          if (rem_q == CNT_W'(1)) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (vld_sr_q == '0) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

`ifdef PIPE_ISSUE_PERF_EN
    stall_d = stall_q;
    if (state_q == S_IDLE && start) begin
      stall_d = '0;
    end else if (state_q == S_ISSUE && credits_q == '0 && stall_q != '1) begin
      stall_d = stall_q + 32'd1;
    end
`endif
  end

  assign busy       = (state_q != S_IDLE);
  assign done       = (state_q == S_DONE);
  assign res_valid  = vld_sr_q[LATENCY-1];
  assign res_last   = last_sr_q[LATENCY-1];
  assign credit_err = credit_err_q;
`ifdef PIPE_ISSUE_PERF_EN
  assign stall_cycles = stall_q;
`endif

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (reset) begin
      state_q      <= S_IDLE;
      addr_q       <= '0;
      rem_q        <= '0;
      credits_q    <= CRED_MAX;
      vld_sr_q     <= '0;
      last_sr_q    <= '0;
      credit_err_q <= 1'b0;
`ifdef PIPE_ISSUE_PERF_EN
      stall_q      <= '0;
`endif
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      rem_q        <= rem_d;
      credits_q    <= credits_d;
      vld_sr_q     <= vld_sr_d;
      last_sr_q    <= last_sr_d;
      credit_err_q <= credit_err_d;
`ifdef PIPE_ISSUE_PERF_EN
      stall_q      <= stall_d;
`endif
    end
  end

endmodule
